// File: rtl/route_split.sv
// Pulse-stream splitter: routes each pulse on AI to AO1 or AO2 (steered or round-robin),
// buffering per channel in saturating pending counters. Optional macro ROUTE_SPLIT_CNT_OUT_EN exposes CNT1/CNT2.
module route_split #(
  parameter int CNT_W = 3
) (
  input  logic             TI,
  input  logic             RSTN,
  input  logic             AI,
  input  logic             SEL,
  input  logic             RR,
  input  logic             RDY1,
  input  logic             RDY2,
  output logic             AO1,
  output logic             AO2,
  output logic             OVF
`ifdef ROUTE_SPLIT_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0] CNT1,
  output logic [CNT_W-1:0] CNT2
`endif
);

  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = 1;

  logic             ptr;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic [CNT_W-1:0] cnt1_nxt, cnt2_nxt;
  logic             target;
  logic             inc1, inc2;
  logic             dec1, dec2;
  logic             drop1, drop2;

  // A full counter with an increment and no decrement holds: that pulse is the dropped one.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    if (inc && !dec)
      next_cnt = (cnt == MAXC) ? cnt : cnt + ONE;
    else if (dec && !inc)
      next_cnt = cnt - ONE;
    else
      next_cnt = cnt;
  endfunction

  always_comb begin
    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    target   = RR ? ptr : SEL;
    inc1     = AI & ~target;
    inc2     = AI & target;
    dec1     = RDY1 & ((cnt1 != '0) | inc1);
    dec2     = RDY2 & ((cnt2 != '0) | inc2);
    drop1    = inc1 & ~dec1 & (cnt1 == MAXC);
    drop2    = inc2 & ~dec2 & (cnt2 == MAXC);
    cnt1_nxt = next_cnt(cnt1, inc1, dec1);
    cnt2_nxt = next_cnt(cnt2, inc2, dec2);
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge TI or negedge RSTN) begin
    if (!RSTN) begin
      ptr  <= 1'b0;
      cnt1 <= '0;
      cnt2 <= '0;
      AO1  <= 1'b0;
      AO2  <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      if (AI && RR)
        ptr <= ~ptr;
      cnt1 <= cnt1_nxt;
      cnt2 <= cnt2_nxt;
      AO1  <= dec1;
      AO2  <= dec2;
      if (drop1 || drop2)
        OVF <= 1'b1;
    end
  end

`ifdef ROUTE_SPLIT_CNT_OUT_EN
  assign CNT1 = cnt1;
  assign CNT2 = cnt2;
`endif

  // Simulation-time sanity properties; synthesis ignores concurrent assertions.
  a_ovf_sticky : assert property (@(posedge TI) disable iff (!RSTN) OVF |=> OVF);
  a_ao1_needs_rdy : assert property (@(posedge TI) disable iff (!RSTN) !RDY1 |=> !AO1);
  a_ao2_needs_rdy : assert property (@(posedge TI) disable iff (!RSTN) !RDY2 |=> !AO2);

endmodule
